// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory request/response,
// redirect from execute and the instruction stream to decode.
interface inst_fetch_queue_if;
    logic [31:0] inst_mem_address;
    logic        inst_mem_is_ready;
    logic        inst_mem_is_valid;
    logic [31:0] inst_mem_read_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        exception;

    modport master (
        output inst_mem_address,
        output inst_mem_is_ready,
        input  inst_mem_is_valid,
        input  inst_mem_read_data,
        input  redirect,
        input  redirect_pc,
        input  stall,
        output inst_valid,
        output inst,
        output inst_pc,
        output exception
    );

    modport slave (
        input  inst_mem_address,
        input  inst_mem_is_ready,
        output inst_mem_is_valid,
        output inst_mem_read_data,
        output redirect,
        output redirect_pc,
        output stall,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        input  exception
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Sequential prefetcher with a PC-tagged instruction FIFO ahead of decode.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module inst_fetch_queue #(
    parameter logic [31:0] RESET = 32'h0000_0000,
    parameter int          DEPTH = 4
) (
    input logic                clk,
    input logic                reset,
    inst_fetch_queue_if.master bus
);
    localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW    = AW + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] pc_rd;
    logic [AW-1:0] pc_wr;
    logic          exc;

    logic [31:0] pc_q   [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [31:0] tag_q  [DEPTH];

    logic          issue;
    logic          resp;
    logic          accept;
    logic          q_valid;
    logic          bypass;
    logic          pop;
    logic          push;
    logic [31:0]   resp_pc;
    logic [CW:0]   in_use;

    // Queue slots are reserved at issue time, so a response never finds it full.
    assign in_use  = {1'b0, count} + {1'b0, outstanding};
    assign issue   = reset && !bus.redirect && !exc && (in_use < LIMIT);
    assign resp    = bus.inst_mem_is_valid;
    assign accept  = resp && (drop == '0) && !bus.redirect && !exc;
    assign q_valid = (count != '0);
    assign resp_pc = pc_q[pc_rd];

`ifdef FETCH_BYPASS_EN
    assign bypass = accept && !q_valid;
`else
    assign bypass = 1'b0;
`endif

    assign pop  = q_valid && !bus.stall && !bus.redirect;
    assign push = accept && !(bypass && !bus.stall);

    assign bus.inst_mem_address  = fetch_pc;
    assign bus.inst_mem_is_ready = issue;
    assign bus.exception         = exc;

    always_comb begin
        bus.inst_valid = q_valid || bypass;
        bus.inst       = NOP;
        bus.inst_pc    = tag_q[rd_ptr];
        if (q_valid) begin
            bus.inst    = data_q[rd_ptr];
            bus.inst_pc = tag_q[rd_ptr];
        end else if (bypass) begin
            bus.inst    = bus.inst_mem_read_data;
            bus.inst_pc = resp_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            pc_rd       <= '0;
            pc_wr       <= '0;
            exc         <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= RESET;
                data_q[i] <= NOP;
                tag_q[i]  <= RESET;
            end
        end else begin
            // The PC FIFO tracks every in-flight request, dropped or not.
            if (issue) begin
                pc_q[pc_wr] <= fetch_pc;
                pc_wr       <= pc_wr + AW'(1);
            end
            if (resp) begin
                pc_rd <= pc_rd + AW'(1);
            end

            unique case ({issue, resp})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase

            if (bus.redirect) begin
                fetch_pc <= bus.redirect_pc;
                count    <= '0;
                rd_ptr   <= wr_ptr;
                drop     <= outstanding - CW'(resp);
                if (bus.redirect_pc[1:0] != 2'b00) begin
                    exc <= 1'b1;
                end
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
                if (push) begin
                    data_q[wr_ptr] <= bus.inst_mem_read_data;
                    tag_q[wr_ptr]  <= resp_pc;
                    wr_ptr         <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                unique case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue against a request/queue level model
// with an in-order, variable-latency instruction memory.
module tb_inst_fetch_queue;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk;
    logic reset;

    inst_fetch_queue_if bus ();

    inst_fetch_queue #(
        .RESET (RESET_PC),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    req_t        fly[$];
    ent_t        vis[$];
    logic [31:0] m_pc;
    bit          m_exc;
    int          cyc;
    int          lat_lo;
    int          lat_hi;
    int          n_cmp;
    int          n_bad;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // One clock: drive inputs, report observed and expected outputs, advance the model.
    // Layout: {ready, address, valid, inst, pc-if-valid, exception}.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                        output logic [98:0] o, output logic [98:0] e);
        logic        rv;
        logic [31:0] raddr;
        logic [31:0] rdata;
        bit          rstale;
        logic        er;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ep;
        bit          byp;
        @(negedge clk);
        rv     = 1'b0;
        raddr  = 32'h0;
        rdata  = 32'h0;
        rstale = 1'b1;
        if (fly.size() > 0 && fly[0].due <= cyc) begin
            rv     = 1'b1;
            raddr  = fly[0].addr;
            rdata  = mem_word(raddr);
            rstale = fly[0].stale;
        end
        bus.stall              = st;
        bus.redirect           = rd;
        bus.redirect_pc        = rpc;
        bus.inst_mem_is_valid  = rv;
        bus.inst_mem_read_data = rv ? rdata : $urandom;
        #1;
        er  = !rd && !m_exc && (vis.size() + fly.size() < DEPTH);
        byp = 1'b0;
        if (vis.size() > 0) begin
            ev = 1'b1;
            ei = vis[0].w;
            ep = vis[0].pc;
        end else begin
            ev = 1'b0;
            ei = NOP;
            ep = 32'h0;
        end
`ifdef FETCH_BYPASS_EN
        if (vis.size() == 0 && rv && !rstale && !rd && !m_exc) begin
            ev  = 1'b1;
            ei  = rdata;
            ep  = raddr;
            byp = 1'b1;
        end
`endif
        e = {er, m_pc, ev, ei, ev ? ep : 32'h0, m_exc};
        o = {bus.inst_mem_is_ready, bus.inst_mem_address, bus.inst_valid,
             bus.inst, bus.inst_valid ? bus.inst_pc : 32'h0, bus.exception};
        @(posedge clk);
        if (rd) begin
            vis.delete();
            foreach (fly[i]) fly[i].stale = 1'b1;
            if (rv) void'(fly.pop_front());
            m_pc = rpc;
            if (rpc[1:0] != 2'b00) m_exc = 1'b1;
        end else begin
            if (ev && !st && !byp) void'(vis.pop_front());
            if (rv) begin
                void'(fly.pop_front());
                if (!rstale && !m_exc && !(byp && !st)) begin
                    vis.push_back('{pc: raddr, w: rdata});
                end
            end
            if (er) begin
                fly.push_back('{addr: m_pc,
                                due: cyc + int'($urandom_range(lat_hi, lat_lo)),
                                stale: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset                  = 1'b0;
        bus.stall              = 1'b0;
        bus.redirect           = 1'b0;
        bus.redirect_pc        = 32'h0;
        bus.inst_mem_is_valid  = 1'b0;
        bus.inst_mem_read_data = 32'h0;
        fly.delete();
        vis.delete();
        m_pc  = RESET_PC;
        m_exc = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        // Assert reset mid-cycle while the block is busy; it must clear at once.
        @(negedge clk);
        #2 reset = 1'b0;
        bus.redirect          = 1'b0;
        bus.inst_mem_is_valid = 1'b0;
        #1;
        n_cmp += 6;
        if (bus.inst_mem_is_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready got=%b exp=0", bus.inst_mem_is_ready);
        end
        if (bus.inst_mem_address !== RESET_PC) begin
            n_bad++;
            $display("FAIL reset_addr got=%h exp=%h", bus.inst_mem_address, RESET_PC);
        end
        if (bus.inst_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid got=%b exp=0", bus.inst_valid);
        end
        if (bus.inst !== NOP) begin
            n_bad++;
            $display("FAIL reset_inst got=%h exp=%h", bus.inst, NOP);
        end
        if (bus.inst_pc !== RESET_PC) begin
            n_bad++;
            $display("FAIL reset_pc got=%h exp=%h", bus.inst_pc, RESET_PC);
        end
        if (bus.exception !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_exc got=%b exp=0", bus.exception);
        end
        do_reset();
    endtask

    task automatic test_sequential();
        logic [98:0] o;
        logic [98:0] e;
        int          first_req;
        int          first_val;
        int          exp_gap;
        do_reset();
        lat_lo    = 1;
        lat_hi    = 1;
        first_req = -1;
        first_val = -1;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, 1'b0, 32'h0, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL seq cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            if (o[98] && first_req < 0) first_req = i;
            if (o[65] && first_val < 0) first_val = i;
        end
`ifdef FETCH_BYPASS_EN
        exp_gap = 1;
`else
        exp_gap = 2;
`endif
        n_cmp++;
        if (first_req != 0 || first_val - first_req != exp_gap) begin
            n_bad++;
            $display("FAIL seq_latency got req=%0d val=%0d exp req=0 gap=%0d",
                     first_req, first_val, exp_gap);
        end
    endtask

    task automatic test_stall_full();
        logic [98:0] o;
        logic [98:0] e;
        int          issued;
        do_reset();
        lat_lo = 1;
        lat_hi = 1;
        issued = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 32'h0, o, e);
            issued += int'(o[98]);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL stall cyc=%0d got=%h exp=%h", cyc, o, e);
            end
        end
        n_cmp += 2;
        if (issued != DEPTH) begin
            n_bad++;
            $display("FAIL stall_issued got=%0d exp=%0d", issued, DEPTH);
        end
        if (o[65] !== 1'b1 || o[32:1] !== RESET_PC) begin
            n_bad++;
            $display("FAIL stall_head got v=%b pc=%h exp v=1 pc=%h", o[65], o[32:1], RESET_PC);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 32'h0, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL unstall cyc=%0d got=%h exp=%h", cyc, o, e);
            end
        end
    endtask

    task automatic test_redirect();
        logic [98:0] o;
        logic [98:0] e;
        bit          seen;
        do_reset();
        lat_lo = 3;
        lat_hi = 3;
        seen   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 32'h0, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL redir_pre cyc=%0d got=%h exp=%h", cyc, o, e);
            end
        end
        step(1'b0, 1'b1, 32'h200, o, e);
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL redir cyc=%0d got=%h exp=%h", cyc, o, e);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 32'h0, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL redir_post cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            if (o[65] && !seen) begin
                seen = 1'b1;
                n_cmp++;
                if (o[32:1] !== 32'h200) begin
                    n_bad++;
                    $display("FAIL redir_first got=%h exp=00000200", o[32:1]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [98:0] o;
        logic [98:0] e;
        bit          saw_addr0;
        bit          saw_pc0;
        do_reset();
        lat_lo    = 1;
        lat_hi    = 2;
        saw_addr0 = 1'b0;
        saw_pc0   = 1'b0;
        step(1'b0, 1'b1, 32'hFFFF_FFF4, o, e);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 32'h0, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            if (o[98] && o[97:66] == 32'h0) saw_addr0 = 1'b1;
            if (o[65] && o[32:1] == 32'h0) saw_pc0 = 1'b1;
        end
        n_cmp++;
        if (!(saw_addr0 && saw_pc0)) begin
            n_bad++;
            $display("FAIL wrap_zero got addr0=%b pc0=%b exp 1 1", saw_addr0, saw_pc0);
        end
    endtask

    task automatic test_exception();
        logic [98:0] o;
        logic [98:0] e;
        do_reset();
        lat_lo = 2;
        lat_hi = 2;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'h0, o, e);
        end
        step(1'b0, 1'b1, 32'h202, o, e);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, (i == 5), 32'h300, o, e);
            n_cmp += 2;
            if (o !== e) begin
                n_bad++;
                $display("FAIL exc cyc=%0d got=%h exp=%h", cyc, o, e);
            end
            if (o[0] !== 1'b1 || o[98] !== 1'b0 || o[65] !== 1'b0) begin
                n_bad++;
                $display("FAIL exc_sticky got exc=%b rdy=%b v=%b exp 1 0 0", o[0], o[98], o[65]);
            end
        end
        do_reset();
        #1;
        n_cmp++;
        if (bus.exception !== 1'b0) begin
            n_bad++;
            $display("FAIL exc_clear got=%b exp=0", bus.exception);
        end
    endtask

    task automatic test_random();
        logic [98:0] o;
        logic [98:0] e;
        logic        rd;
        do_reset();
        lat_lo = 1;
        lat_hi = 4;
        for (int i = 0; i < 500; i++) begin
            rd = ($urandom_range(99, 0) < 5);
            step(($urandom_range(99, 0) < 30), rd, $urandom & 32'hFFFF_FFFC, o, e);
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, o, e);
            end
        end
    endtask

    initial begin
        reset                  = 1'b0;
        bus.stall              = 1'b0;
        bus.redirect           = 1'b0;
        bus.redirect_pc        = 32'h0;
        bus.inst_mem_is_valid  = 1'b0;
        bus.inst_mem_read_data = 32'h0;
        n_cmp  = 0;
        n_bad  = 0;
        cyc    = 0;
        lat_lo = 1;
        lat_hi = 1;
        m_pc   = RESET_PC;
        m_exc  = 1'b0;
        do_reset();
        test_reset();
        test_sequential();
        test_stall_full();
        test_redirect();
        test_wrap();
        test_exception();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction prefetch stage that sits directly upstream of `IF_ID` in the three-stage pipeline. It generates sequential fetch addresses, issues pipelined requests to instruction memory, and buffers returned words in a DEPTH-entry FIFO tagged with their PC. It presents them to decode with a stall-aware valid interface. Branch/jump redirects from execute flush the queue and discard in-flight responses.

## Interface
- `RESET`, 32'h0000_0000, PC of the first fetch after reset.
- `DEPTH`, 4, queue entries; power of two, 2..8.

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `inst_mem_address`  out  32  fetch address (word aligned).
- `inst_mem_is_ready`  out  1  fetch request valid this cycle; memory always accepts.
- `inst_mem_is_valid`  in  1  response valid; responses return in order, latency >= 1.
- `inst_mem_read_data`  in  32  response word.
- `redirect`  in  1  execute-stage control-flow change.
- `redirect_pc`  in  32  new fetch target.
- `stall`  in  1  decode not accepting this cycle.
- `inst_valid`  out  1  `inst`/`inst_pc` hold a valid instruction.
- `inst`  out  32  instruction word; 32'h0000_0013 (NOP) when not valid.
- `inst_pc`  out  32  PC of `inst`.
- `exception`  out  1  sticky misaligned-redirect flag.

## Operation
- State: `fetch_pc`, FIFO (`count`, rd/wr pointers), `outstanding` (requests without responses), `drop` (responses still to discard), sticky `exc`.
- Issue: `inst_mem_is_ready = !redirect && !exc && (count + outstanding < DEPTH)`. On issue, `fetch_pc += 4`, modulo 2^32 (32'hFFFF_FFFC wraps to 0). `outstanding` increments on issue and decrements on a response. Simultaneous issue and response leave it unchanged.
- Response with `drop > 0`: discarded, `drop--`. Otherwise the response is pushed with its PC. Push PC comes from a per-entry PC recorded at issue time: a DEPTH-deep PC FIFO written on issue and read on response.
- Pop: `inst_valid && !stall`. Push and pop may occur in the same cycle, including when the queue is full.
- Redirect (priority over everything):
  - No pop takes effect and no request is issued that cycle.
  - Next cycle: `count = 0`, `fetch_pc = redirect_pc`.
  - `drop = outstanding` minus 1 if a response arrives that same cycle. That response is itself discarded, and any pending `drop` is included.
- `redirect_pc[1:0] != 0`: `exc` is set and `exception` goes to 1, sticky until reset. Queue is flushed; no further requests are issued.

## Timing
- Reset (asynchronous, active-low) values:
  - `inst_mem_address = RESET`
  - `inst_mem_is_ready = 0`
  - `inst_valid = 0`
  - `inst = 32'h0000_0013`
  - `inst_pc = RESET`
  - `exception = 0`
  - `count = outstanding = drop = 0`
- The first request is issued on the first clock edge after reset release. `inst_mem_is_ready = 1`, address `RESET`.
- A response latched at edge N is visible on `inst_valid` after edge N (registered queue output). Minimum request-to-decode latency is memory latency + 1.
- Redirect at edge R: the first request to `redirect_pc` is issued in cycle R+1. Stale responses arriving after R are never presented.
- Reset asserted mid-operation: all state is cleared immediately. Responses arriving after reset release belong to pre-reset requests and must not occur; memory is reset together with this block.

## Configuration
- `FETCH_BYPASS_EN` defined: if `count == 0` and a non-dropped response arrives, it drives `inst_valid/inst/inst_pc` combinationally that same cycle. If `!stall`, it is consumed without being written; otherwise it is written. Minimum latency becomes memory latency.
- Undefined: all responses go through the queue, as described in Timing.

## Test plan
- Reset release, 1-cycle memory, `stall = 0`, RESET = 0x100:
  - requests are issued at 0x100, 0x104, 0x108…
  - `inst_valid` rises 2 cycles after the first request, with `inst_pc` = 0x100, 0x104… back to back.
- Hold `stall = 1`, DEPTH = 4:
  - exactly 4 requests are issued, then `inst_mem_is_ready = 0`
  - `inst_valid = 1`, holding 0x100 unchanged
  - release `stall`: words pop one per cycle, and issue resumes at 0x110.
- 3-cycle memory latency, `redirect = 1`, `redirect_pc = 0x200` with 2 requests outstanding:
  - the 2 stale responses are discarded
  - the next presented `inst_pc` is 0x200, with no stale word ever showing `inst_valid`.
- `redirect_pc = 0x202`:
  - `exception = 1` next cycle and stays 1
  - `inst_mem_is_ready` stays 0
  - `inst_valid = 0`
  - cleared only by `reset = 0`.
- `fetch_pc` at 0xFFFF_FFFC: the next issued address is 0x0000_0000, and `inst_pc` wraps accordingly.
- `FETCH_BYPASS_EN`, empty queue, 1-cycle memory: `inst_valid` is asserted in the same cycle as `inst_mem_is_valid`, with matching `inst`.
